// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider.
// start is accepted only while busy=0; done pulses one cycle when results are valid.
interface seq_divider_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one SHIFT plus one SUBTRACT cycle per quotient bit.
// A divide-by-zero request skips the iterations and reports all-ones quotient.
module seq_divider #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            reset,
  seq_divider_if.slave    bus,
  output logic [1:0]      dbg_state_o
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SUBTRACT, FINISH} state_e;

  state_e        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic [N:0]    diff;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    diff    = a_q - {1'b0, m_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = '0;
          q_d   = bus.dividend;
          m_d   = bus.divisor;
          cnt_d = CW'(N);
          if (bus.divisor != '0) begin
            state_d = SHIFT;
          end else begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = FINISH;
          end
        end
      end
      SHIFT: begin
        // A[N] is always 0 between iterations, so dropping it loses nothing.
        {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
        state_d    = SUBTRACT;
      end
      SUBTRACT: begin
        if (!diff[N]) begin
          a_d = diff;
          q_d = {q_q[N-1:1], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          quot_d  = q_d;
          rem_d   = a_d[N-1:0];
          dbz_d   = 1'b0;
          state_d = FINISH;
        end else begin
          state_d = SHIFT;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FINISH);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=4): latency, results, divide-by-zero,
// ignored start while busy, abort by reset and a back-to-back sweep.
module tb_seq_divider;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_err;

  seq_divider_if #(.N(4)) bus ();

  seq_divider #(.N(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle from IDLE, scramble operands afterwards and
  // watch the operation until busy drops (bounded).
  task automatic do_op(input logic [3:0] dd, input logic [3:0] dv,
                       output int done_at, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    done_at  = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start    = 1'b0;
        bus.dividend = 4'hA;
        bus.divisor  = 4'h6;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_at = k;
      end
      if (!bus.busy) break;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl busy=%b done=%b required busy=0 done=0", bus.busy, bus.done);
    end
    n_vec++;
    if (bus.quotient !== 4'd0 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_results q=%0d r=%0d dbz=%b required 0 0 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    n_vec++;
    if (dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got %0d required 0", dbg_state);
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] dd, input logic [3:0] dv,
                          input logic [3:0] exp_q, input logic [3:0] exp_r, input logic exp_z,
                          input int exp_lat);
    int done_at, busy_cnt, done_cnt;
    do_op(dd, dv, done_at, busy_cnt, done_cnt);
    n_vec++;
    if (done_at != exp_lat || busy_cnt != exp_lat || done_cnt != 1) begin
      n_err++;
      $display("FAIL %s_timing done_at=%0d busy=%0d pulses=%0d required %0d %0d 1",
               name, done_at, busy_cnt, done_cnt, exp_lat, exp_lat);
    end
    n_vec++;
    if (bus.quotient !== exp_q || bus.remainder !== exp_r || bus.div_by_zero !== exp_z) begin
      n_err++;
      $display("FAIL %s_result q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
               name, bus.quotient, bus.remainder, bus.div_by_zero, exp_q, exp_r, exp_z);
    end
  endtask

  task automatic test_basic();
    check_op("div_13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 9);
  endtask

  task automatic test_boundaries();
    check_op("div_15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 9);
    check_op("div_2_7",  4'd2,  4'd7, 4'd0,  4'd2, 1'b0, 9);
    check_op("div_5_5",  4'd5,  4'd5, 4'd1,  4'd0, 1'b0, 9);
  endtask

  task automatic test_div_zero();
    check_op("div_9_0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1);
    check_op("div_8_2", 4'd8, 4'd2, 4'd4,  4'd0, 1'b0, 9);
  endtask

  task automatic test_ignore_start();
    int done_at, done_cnt;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    done_at  = 0;
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      // cycle 4 after the start edge is SUBTRACT of the second iteration
      if (k == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 4'd15;
        bus.divisor  = 4'd1;
      end
      if (k == 5) bus.start = 1'b0;
      if (bus.done) begin
        done_cnt++;
        done_at = k;
      end
      if (!bus.busy) break;
    end
    n_vec++;
    if (done_at != 9 || done_cnt != 1) begin
      n_err++;
      $display("FAIL ignore_timing done_at=%0d pulses=%0d required 9 1", done_at, done_cnt);
    end
    n_vec++;
    if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1) begin
      n_err++;
      $display("FAIL ignore_result q=%0d r=%0d required q=4 r=1", bus.quotient, bus.remainder);
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.quotient !== 4'd4 || bus.remainder !== 4'd1) begin
      n_err++;
      $display("FAIL ignore_hold busy=%b q=%0d r=%0d required busy=0 q=4 r=1",
               bus.busy, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_abort();
    int done_cnt;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    done_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done) done_cnt++;
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL abort_ctrl busy=%b done=%b state=%0d required 0 0 0",
               bus.busy, bus.done, dbg_state);
    end
    n_vec++;
    if (bus.quotient !== 4'd0 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL abort_results q=%0d r=%0d dbz=%b required 0 0 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    n_vec++;
    if (done_cnt != 0) begin
      n_err++;
      $display("FAIL abort_no_done pulses=%0d required 0", done_cnt);
    end
    check_op("div_14_4", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 9);
  endtask

  task automatic test_back_to_back();
    logic [3:0] dd, dv;
    int         cnt, exp_lat;
    logic [3:0] exp_q, exp_r;
    logic       exp_z;
    bit         timed_out;
    timed_out = 1'b0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    for (int i = 0; i < 256; i++) begin
      dd = 4'(i >> 4);
      dv = 4'(i & 15);
      if (dv == 4'd0) begin
        exp_q = 4'hF;
        exp_r = dd;
        exp_z = 1'b1;
      end else begin
        exp_q = dd / dv;
        exp_r = dd % dv;
        exp_z = 1'b0;
      end
      // one FINISH->IDLE cycle plus the IDLE capture cycle precede later ops
      exp_lat = ((dv == 4'd0) ? 1 : 9) + ((i == 0) ? 0 : 1);
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus.done && cnt < 30);
      n_vec++;
      if (cnt != exp_lat) begin
        n_err++;
        $display("FAIL sweep_timing %0d/%0d done after %0d cycles required %0d", dd, dv, cnt, exp_lat);
        if (!bus.done) timed_out = 1'b1;
      end
      n_vec++;
      if (bus.quotient !== exp_q || bus.remainder !== exp_r || bus.div_by_zero !== exp_z) begin
        n_err++;
        $display("FAIL sweep_result %0d/%0d q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                 dd, dv, bus.quotient, bus.remainder, bus.div_by_zero, exp_q, exp_r, exp_z);
      end
      if (timed_out) break;
      if (i < 255) begin
        bus.dividend = 4'((i + 1) >> 4);
        bus.divisor  = 4'((i + 1) & 15);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_idle busy=%b required 0", bus.busy);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
